// File: rtl/axi_master_pkg.sv
// Shared types and constants for the CPU-to-AXI single-beat master bridge.
// Bus widths match the SRAM_wrapper interconnect (ID 4, addr/data 32, AXI3-style 4-bit LEN).
package axi_master_pkg;

    localparam int AXI_ID_BITS    = 4;
    localparam int AXI_ADDR_BITS  = 32;
    localparam int AXI_DATA_BITS  = 32;
    localparam int AXI_LEN_BITS   = 4;
    localparam int AXI_SIZE_BITS  = 3;
    localparam int AXI_BURST_BITS = 2;
    localparam int AXI_STRB_BITS  = AXI_DATA_BITS / 8;
    localparam int AXI_RESP_BITS  = 2;

    localparam logic [AXI_SIZE_BITS-1:0]  SIZE_WORD  = 3'b010;
    localparam logic [AXI_BURST_BITS-1:0] BURST_INCR = 2'b01;
    localparam logic [AXI_LEN_BITS-1:0]   LEN_SINGLE = '0;
    localparam logic [AXI_RESP_BITS-1:0]  RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW,
        W,
        B,
        DONE
    } state_t;

    function automatic logic resp_is_err(input logic [AXI_RESP_BITS-1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/cpu_axi_master.sv
// Turns one CPU memory access into a single-beat AXI read or write, stalling the core until done.
// One transaction outstanding; every bus output is a pure decode of the registered state.
module cpu_axi_master
    import axi_master_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = '0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      core_req,
    input  logic                      core_wr,
    input  logic [31:0]               core_addr,
    input  logic [3:0]                core_web,
    input  logic [31:0]               core_wdata,
    output logic [31:0]               core_rdata,
    output logic                      core_stall,
    output logic                      core_err,

    output logic [AXI_ID_BITS-1:0]    ARID,
    output logic [AXI_ADDR_BITS-1:0]  ARADDR,
    output logic [AXI_LEN_BITS-1:0]   ARLEN,
    output logic [AXI_SIZE_BITS-1:0]  ARSIZE,
    output logic [AXI_BURST_BITS-1:0] ARBURST,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [AXI_ID_BITS-1:0]    RID,
    input  logic [AXI_DATA_BITS-1:0]  RDATA,
    input  logic [AXI_RESP_BITS-1:0]  RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY,

    output logic [AXI_ID_BITS-1:0]    AWID,
    output logic [AXI_ADDR_BITS-1:0]  AWADDR,
    output logic [AXI_LEN_BITS-1:0]   AWLEN,
    output logic [AXI_SIZE_BITS-1:0]  AWSIZE,
    output logic [AXI_BURST_BITS-1:0] AWBURST,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [AXI_DATA_BITS-1:0]  WDATA,
    output logic [AXI_STRB_BITS-1:0]  WSTRB,
    output logic                      WLAST,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [AXI_ID_BITS-1:0]    BID,
    input  logic [AXI_RESP_BITS-1:0]  BRESP,
    input  logic                      BVALID,
    output logic                      BREADY
);

    state_t                     state;
    logic                       got_beat;
    logic [AXI_RESP_BITS-1:0]   resp_q;

    logic [31:2]                addr_q;
    logic [3:0]                 web_q;
    logic [31:0]                wdata_q;

    // Response IDs and the byte offset are irrelevant to a single-outstanding word master.
    logic                       unused_ok;
    assign unused_ok = ^{RID, BID, core_addr[1:0]};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            got_beat   <= 1'b0;
            resp_q     <= RESP_OKAY;
            core_rdata <= '0;
            core_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    got_beat <= 1'b0;
                    if (core_req) begin
                        state <= core_wr ? AW : AR;
                    end
                end
                AR: begin
                    if (ARREADY) begin
                        state <= R;
                    end
                end
                R: begin
                    // Only the first beat is kept; any extra beats are accepted and dropped.
                    if (RVALID) begin
                        if (!got_beat) begin
                            core_rdata <= RDATA;
                            resp_q     <= RRESP;
                            got_beat   <= 1'b1;
                        end
                        if (RLAST) begin
                            state    <= DONE;
                            core_err <= resp_is_err(got_beat ? resp_q : RRESP);
                        end
                    end
                end
                AW: begin
                    if (AWREADY) begin
                        state <= W;
                    end
                end
                W: begin
                    if (WREADY) begin
                        state <= B;
                    end
                end
                B: begin
                    if (BVALID) begin
                        state    <= DONE;
                        core_err <= resp_is_err(BRESP);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request payload is frozen on acceptance so later core_* wiggles cannot disturb VALID payloads.
    always_ff @(posedge ACLK) begin
        if (state == IDLE && core_req) begin
            addr_q  <= core_addr[31:2];
            web_q   <= core_web;
            wdata_q <= core_wdata;
        end
    end

    assign core_stall = core_req && (state != DONE);

    assign ARID    = MASTER_ID;
    assign ARADDR  = {addr_q, 2'b00};
    assign ARLEN   = LEN_SINGLE;
    assign ARSIZE  = SIZE_WORD;
    assign ARBURST = BURST_INCR;
    assign ARVALID = (state == AR);
    assign RREADY  = (state == R);

    assign AWID    = MASTER_ID;
    assign AWADDR  = {addr_q, 2'b00};
    assign AWLEN   = LEN_SINGLE;
    assign AWSIZE  = SIZE_WORD;
    assign AWBURST = BURST_INCR;
    assign AWVALID = (state == AW);

    assign WDATA   = wdata_q;
    assign WSTRB   = web_q;
    assign WLAST   = 1'b1;
    assign WVALID  = (state == W);
    assign BREADY  = (state == B);

endmodule
